// File: rtl/bk_pkg.sv
// Shared types for the save/load sector controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bk_pkg;

  localparam int BK_LBA_W = 32;

  typedef enum logic [2:0] {
    BK_IDLE,
    BK_ISSUE,
    BK_XFER,
    BK_DONE,
    BK_ERR
  } bk_state_t;

endpackage

// File: rtl/bk_timeout.sv
// Free-running ack-wait counter with clear/enable; flags when it reaches all-ones.
// Latency: expired_o is a direct decode of the registered count.
// Backpressure: none; the owner clears it whenever the wait is over.
module bk_timeout #(
  parameter int TMO_W = 24
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TMO_W-1:0] cnt_q;

  // Count while enabled; a clear always wins so each wait starts from zero.
  always_ff @(posedge clk_sys) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = &cnt_q;

endmodule

// File: rtl/bk_sector_ctrl.sv
// Moves one slot of nvram sectors to/from the HPS virtual SD interface per save/load request.
// Latency: first sd_rd/sd_wr two cycles after the request edge is registered; one sector per ack pulse.
// Backpressure: waits on sd_ack rise/fall per sector; aborts on ack timeout or a new ROM download.
module bk_sector_ctrl
  import bk_pkg::*;
#(
  parameter int SECT_BITS = 6,
  parameter int SLOT_BITS = 2,
  parameter int TMO_W     = 24
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 downloading,
  input  logic                 img_mounted,
  input  logic                 img_size_nz,
  input  logic                 img_readonly,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic                 sd_ack,
  output logic [BK_LBA_W-1:0]  sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  output logic                 bk_ena,
  output logic                 bk_loading,
  output logic                 bk_busy,
  output logic                 bk_error
);

  bk_state_t state_q, state_d;

  logic                 dl_q, ack_q;
  logic                 ldg_q, svg_q, ld_edge_q, sv_edge_q;
  logic                 bk_ena_q;
  logic                 sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic                 busy_q, busy_d, loading_q, loading_d, error_q, error_d;
  logic                 ld_q, ld_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic [SECT_BITS-1:0] sector_q, sector_d;
  logic                 tmo_exp;

  // Requests only count while a writable image is mounted.
  wire ld_g      = load_req & bk_ena_q;
  wire sv_g      = save_req & bk_ena_q;
  wire dl_rise   = downloading & ~dl_q;
  wire ack_rise  = sd_ack & ~ack_q;
  wire ack_fall  = ~sd_ack & ack_q;
  wire accept    = ld_edge_q | sv_edge_q;
  wire sect_last = &sector_q;

  bk_timeout #(.TMO_W(TMO_W)) u_tmo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .clr_i     ((state_q != BK_ISSUE) | ack_rise),
    .en_i      (state_q == BK_ISSUE),
    .expired_o (tmo_exp)
  );

  // Edge detectors: previous-value registers plus one-cycle registered request pulses.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q      <= 1'b0;
      ack_q     <= 1'b0;
      ldg_q     <= 1'b0;
      svg_q     <= 1'b0;
      ld_edge_q <= 1'b0;
      sv_edge_q <= 1'b0;
    end else begin
      dl_q      <= downloading;
      ack_q     <= sd_ack;
      ldg_q     <= ld_g;
      svg_q     <= sv_g;
      ld_edge_q <= ld_g & ~ldg_q;
      sv_edge_q <= sv_g & ~svg_q;
    end
  end

  // Image availability: a fresh download invalidates it, a writable mount restores it (mount wins).
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bk_ena_q <= 1'b0;
    end else if (downloading && img_mounted && img_size_nz && !img_readonly) begin
      bk_ena_q <= 1'b1;
    end else if (dl_rise) begin
      bk_ena_q <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= BK_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a download start abandons whatever is in flight.
  always_comb begin
    state_d = state_q;
    if (dl_rise) begin
      state_d = BK_IDLE;
    end else begin
      case (state_q)
        BK_IDLE:  if (accept) state_d = BK_ISSUE;
        BK_ISSUE: begin
          if (ack_rise)     state_d = BK_XFER;
          else if (tmo_exp) state_d = BK_ERR;
        end
        BK_XFER:  if (ack_fall) state_d = sect_last ? BK_DONE : BK_ISSUE;
        BK_DONE:  state_d = BK_IDLE;
        BK_ERR:   state_d = BK_IDLE;
        default:  state_d = BK_IDLE;
      endcase
    end
  end

  // FSM outputs and datapath next values; load wins over a same-cycle save.
  always_comb begin
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    busy_d    = busy_q;
    loading_d = loading_q;
    error_d   = error_q;
    ld_d      = ld_q;
    slot_d    = slot_q;
    sector_d  = sector_q;
    if (dl_rise) begin
      sd_rd_d   = 1'b0;
      sd_wr_d   = 1'b0;
      busy_d    = 1'b0;
      loading_d = 1'b0;
    end else begin
      case (state_q)
        BK_IDLE: begin
          if (accept) begin
            ld_d      = ld_edge_q;
            slot_d    = slot;
            sector_d  = '0;
            error_d   = 1'b0;
            busy_d    = 1'b1;
            loading_d = ld_edge_q;
          end
        end
        BK_ISSUE: begin
          if (ack_rise || tmo_exp) begin
            sd_rd_d = 1'b0;
            sd_wr_d = 1'b0;
          end else begin
            sd_rd_d = ld_q;
            sd_wr_d = ~ld_q;
          end
        end
        BK_XFER: begin
          if (ack_fall && !sect_last) sector_d = sector_q + 1'b1;
        end
        BK_DONE: begin
          busy_d    = 1'b0;
          loading_d = 1'b0;
        end
        BK_ERR: begin
          sd_rd_d   = 1'b0;
          sd_wr_d   = 1'b0;
          error_d   = 1'b1;
          busy_d    = 1'b0;
          loading_d = 1'b0;
        end
        default: begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
        end
      endcase
    end
  end

  // Registered outputs and latched operation context.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      loading_q <= 1'b0;
      error_q   <= 1'b0;
      ld_q      <= 1'b0;
      slot_q    <= '0;
      sector_q  <= '0;
    end else begin
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      busy_q    <= busy_d;
      loading_q <= loading_d;
      error_q   <= error_d;
      ld_q      <= ld_d;
      slot_q    <= slot_d;
      sector_q  <= sector_d;
    end
  end

  assign sd_lba     = {{(BK_LBA_W-SLOT_BITS-SECT_BITS){1'b0}}, slot_q, sector_q};
  assign sd_rd      = sd_rd_q;
  assign sd_wr      = sd_wr_q;
  assign bk_ena     = bk_ena_q;
  assign bk_busy    = busy_q;
  assign bk_loading = loading_q;
  assign bk_error   = error_q;

endmodule

// File: tb/tb_bk_sector_ctrl.sv
// Scoreboard bench for bk_sector_ctrl with a simple HPS ack model.
// Latency: n/a.
// Backpressure: HPS model acks each request 5 cycles late for 20 cycles, or never when disabled.
module tb_bk_sector_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset, downloading, img_mounted, img_size_nz, img_readonly;
  logic        load_req, save_req, sd_ack;
  logic [1:0]  slot;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_error;

  typedef struct packed {
    logic        rd;
    logic [31:0] lba;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  int   busy_fall_cyc = 0;
  bit   hps_en = 1'b1;
  bit   saw_loading = 1'b0;

  bk_sector_ctrl #(.SECT_BITS(6), .SLOT_BITS(2), .TMO_W(4)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .downloading  (downloading),
    .img_mounted  (img_mounted),
    .img_size_nz  (img_size_nz),
    .img_readonly (img_readonly),
    .load_req     (load_req),
    .save_req     (save_req),
    .slot         (slot),
    .sd_ack       (sd_ack),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .bk_ena       (bk_ena),
    .bk_loading   (bk_loading),
    .bk_busy      (bk_busy),
    .bk_error     (bk_error)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic push_op(input bit rd, input logic [1:0] s);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(req_t'{rd: rd, lba: (32'(s) << 6) | 32'(i)});
    end
  endtask

  task automatic clear_counts();
    rd_cnt      = 0;
    wr_cnt      = 0;
    saw_loading = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int bound);
    int n = 0;
    while (!bk_busy && n < bound) begin step(); n++; end
    check({tag, "_started"}, bk_busy, 1);
  endtask

  task automatic wait_end(input string tag, input int bound);
    int n = 0;
    while (bk_busy && n < bound) begin step(); n++; end
    check({tag, "_ended"}, bk_busy, 0);
  endtask

  task automatic mount(input bit ro);
    downloading = 1'b1;
    step();
    img_mounted  = 1'b1;
    img_size_nz  = 1'b1;
    img_readonly = ro;
    step();
    img_mounted  = 1'b0;
    img_readonly = 1'b0;
    step();
    downloading = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sd_rd"}, sd_rd, 0);
    check({tag, "_sd_wr"}, sd_wr, 0);
    check({tag, "_sd_lba"}, sd_lba, 0);
    check({tag, "_bk_ena"}, bk_ena, 0);
    check({tag, "_bk_busy"}, bk_busy, 0);
    check({tag, "_bk_loading"}, bk_loading, 0);
    check({tag, "_bk_error"}, bk_error, 0);
  endtask

  // HPS model: acknowledge each pending sector request 5 cycles later, hold ack 20 cycles.
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (hps_en && (sd_rd || sd_wr)) begin
        repeat (5) @(posedge clk_sys);
        #1;
        sd_ack = 1'b1;
        repeat (20) @(posedge clk_sys);
        #1;
        sd_ack = 1'b0;
        last_fall_cyc = cyc;
      end
    end
  end

  // Monitor: pop the expected request on every sd_rd/sd_wr rise.
  initial begin
    logic rd_p   = 1'b0;
    logic wr_p   = 1'b0;
    logic busy_p = 1'b0;
    req_t e;
    forever begin
      @(negedge clk_sys);
      if (bk_loading) saw_loading = 1'b1;
      if (busy_p && !bk_busy) busy_fall_cyc = cyc;
      if ((sd_rd && !rd_p) || (sd_wr && !wr_p)) begin
        check("rd_wr_exclusive", sd_rd & sd_wr, 0);
        if (sd_rd) rd_cnt++;
        else       wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_req", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("req_kind_rd", sd_rd, e.rd);
          check("req_lba", sd_lba, e.lba);
          if (e.rd) check("loading_during_load", bk_loading, 1);
        end
      end
      rd_p   = sd_rd;
      wr_p   = sd_wr;
      busy_p = bk_busy;
    end
  end

  initial begin
    int n;
    reset        = 1'b1;
    downloading  = 1'b0;
    img_mounted  = 1'b0;
    img_size_nz  = 1'b0;
    img_readonly = 1'b0;
    load_req     = 1'b0;
    save_req     = 1'b0;
    slot         = 2'd0;
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Mount handling: read-only image must not enable, writable one must.
    mount(1'b1);
    check("ena_readonly", bk_ena, 0);
    mount(1'b0);
    check("ena_writable", bk_ena, 1);

    // Save slot 2: 64 writes, lba 0x80..0xBF, never loading.
    clear_counts();
    push_op(1'b0, 2'd2);
    slot     = 2'd2;
    save_req = 1'b1;
    wait_start("save2", 10);
    wait_end("save2", 4000);
    check("save2_wr_cnt", wr_cnt, 64);
    check("save2_rd_cnt", rd_cnt, 0);
    check("save2_queue", exp_q.size(), 0);
    check("save2_no_loading", saw_loading, 0);
    // Ack fall is sampled at the next edge, DONE follows, busy is low one cycle after.
    check("save2_busy_lat", busy_fall_cyc - last_fall_cyc, 2);
    save_req = 1'b0;
    step();

    // Simultaneous load and save on slot 1: load must win.
    clear_counts();
    push_op(1'b1, 2'd1);
    slot     = 2'd1;
    load_req = 1'b1;
    save_req = 1'b1;
    wait_start("load1", 10);
    check("load1_loading", bk_loading, 1);
    wait_end("load1", 4000);
    check("load1_rd_cnt", rd_cnt, 64);
    check("load1_wr_cnt", wr_cnt, 0);
    check("load1_queue", exp_q.size(), 0);
    check("load1_loading_off", bk_loading, 0);
    load_req = 1'b0;
    save_req = 1'b0;
    step();

    // Save slot 3 with request and slot inputs toggled mid-transfer.
    clear_counts();
    push_op(1'b0, 2'd3);
    slot     = 2'd3;
    save_req = 1'b1;
    wait_start("save3", 10);
    repeat (300) step();
    save_req = 1'b0;
    repeat (3) step();
    save_req = 1'b1;
    load_req = 1'b1;
    slot     = 2'd0;
    repeat (3) step();
    load_req = 1'b0;
    wait_end("save3", 4000);
    check("save3_wr_cnt", wr_cnt, 64);
    check("save3_rd_cnt", rd_cnt, 0);
    check("save3_queue", exp_q.size(), 0);
    save_req = 1'b0;
    step();

    // Timeout: HPS never acks a load on slot 0.
    hps_en = 1'b0;
    clear_counts();
    exp_q.push_back(req_t'{rd: 1'b1, lba: 32'h0});
    slot     = 2'd0;
    load_req = 1'b1;
    wait_start("tmo", 10);
    wait_end("tmo", 100);
    check("tmo_error", bk_error, 1);
    check("tmo_sd_rd", sd_rd, 0);
    check("tmo_loading", bk_loading, 0);
    check("tmo_rd_cnt", rd_cnt, 1);
    check("tmo_queue", exp_q.size(), 0);
    load_req = 1'b0;
    hps_en   = 1'b1;
    step();

    // New save clears the error; downloading rises at sector 10 and aborts it.
    clear_counts();
    push_op(1'b0, 2'd0);
    save_req = 1'b1;
    wait_start("abort", 10);
    check("abort_err_cleared", bk_error, 0);
    n = 0;
    while (wr_cnt < 11 && n < 2000) begin step(); n++; end
    check("abort_reach_sector10", wr_cnt, 11);
    downloading = 1'b1;
    step();
    check("abort_sd_wr", sd_wr, 0);
    check("abort_busy", bk_busy, 0);
    check("abort_ena", bk_ena, 0);
    check("abort_err_kept", bk_error, 0);
    check("abort_queue_left", exp_q.size(), 53);
    exp_q.delete();
    downloading = 1'b0;
    step();
    save_req = 1'b0;
    step();
    save_req = 1'b1;
    repeat (50) step();
    check("ignored_busy", bk_busy, 0);
    check("ignored_wr_cnt", wr_cnt, 11);
    save_req = 1'b0;
    repeat (30) step();

    // Remount, then reset in the middle of a load.
    mount(1'b0);
    check("remount_ena", bk_ena, 1);
    clear_counts();
    push_op(1'b1, 2'd1);
    slot     = 2'd1;
    load_req = 1'b1;
    wait_start("rstload", 10);
    n = 0;
    while (rd_cnt < 5 && n < 1000) begin step(); n++; end
    check("rstload_reach", rd_cnt, 5);
    reset = 1'b1;
    step();
    check_all_zero("midreset");
    reset    = 1'b0;
    load_req = 1'b0;
    exp_q.delete();
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
